// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART byte stream to program memory writer; holds the BIP core in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          ADDR_LENGTH = 11,
  parameter int          DATA_LENGTH = 16,
  parameter logic [7:0]  START_CMD   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rxData,
  input  logic                   rxDone,
  output logic [ADDR_LENGTH-1:0] addrToMemory,
  output logic [DATA_LENGTH-1:0] dataToMemory,
  output logic                   Wr,
  output logic                   bipReset,
  output logic                   loadDone,
  output logic                   loadError,
  output logic [ADDR_LENGTH:0]   wordCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_BYTE_HI,
    S_BYTE_LO,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [7:0]             hi_q, hi_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [ADDR_LENGTH:0]   cnt_q, cnt_d;
  logic                   wr_q, wr_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]             xor_q, xor_d;
`endif

  logic        start_seen;
  logic [15:0] len_full;
  logic        last_word;

  assign start_seen = rxDone && (rxData == START_CMD);
  assign len_full   = {len_q[15:8], rxData};
  assign last_word  = (32'(cnt_q) + 32'd1) == 32'(len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    data_d  = data_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    // Counters advance in the cycle after the write pulse, independent of incoming bytes.
    if (wr_q) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_seen) begin
          state_d = S_LEN_HI;
          addr_d  = '0;
          cnt_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (rxDone) begin
          len_d   = {rxData, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rxDone) begin
          len_d = len_full;
          if (len_full == 16'd0 || 32'(len_full) > (32'd1 << ADDR_LENGTH)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_BYTE_HI;
          end
        end
      end
      S_BYTE_HI: begin
        if (rxDone) begin
          hi_d    = rxData;
          state_d = S_BYTE_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ rxData;
`endif
        end
      end
      S_BYTE_LO: begin
        if (rxDone) begin
          data_d = {hi_q, rxData};
          wr_d   = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ rxData;
          state_d = last_word ? S_CHECK : S_BYTE_HI;
`else
          state_d = last_word ? S_DONE : S_BYTE_HI;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rxDone) begin
          state_d = (rxData == xor_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Completion is withheld while the final word's write pulse is still on the bus.
  assign loadDone     = (state_q == S_DONE) && !wr_q;
  assign loadError    = (state_q == S_ERROR);
  assign bipReset     = !loadDone;
  assign Wr           = wr_q;
  assign addrToMemory = addr_q;
  assign dataToMemory = data_q;
  assign wordCount    = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader with message-level reference model.
module tb_program_loader;
  localparam int AL = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rxData = 8'h00;
  logic          rxDone = 1'b0;
  logic [AL-1:0] addrToMemory;
  logic [15:0]   dataToMemory;
  logic          Wr;
  logic          bipReset;
  logic          loadDone;
  logic          loadError;
  logic [AL:0]   wordCount;

  program_loader dut (
    .clk(clk), .rst_n(rst_n), .rxData(rxData), .rxDone(rxDone),
    .addrToMemory(addrToMemory), .dataToMemory(dataToMemory), .Wr(Wr),
    .bipReset(bipReset), .loadDone(loadDone), .loadError(loadError),
    .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_addr[$];
  logic [15:0] exp_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && Wr === 1'b1) begin
      if (exp_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wr actual=%0h:%0h expected=none", addrToMemory, dataToMemory);
      end else begin
        int a;
        logic [15:0] d;
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        check("wr_addr", 32'(addrToMemory), a);
        check("wr_data", 32'(dataToMemory), 32'(d));
        check("wr_count", 32'(wordCount), a);
        check("wr_hold", {30'd0, loadDone, bipReset}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxData = b;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Builds a full session from its message-level description and predicts writes and final status.
  task automatic run_session(input int junk, input int n, input logic [15:0] words[$], input bit bad_sum);
    bit ok;
    bit done_exp;
    logic [7:0] xs;
    logic [15:0] w;
    logic [7:0] jb;
    ok = (n >= 1) && (n <= (1 << AL));
    for (int i = 0; i < junk; i++) begin
      jb = 8'($urandom);
      if (jb == 8'hA5) jb = 8'h11;
      send_byte(jb);
    end
    send_byte(8'hA5);
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    xs = 8'h00;
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        w = (i < words.size()) ? words[i] : 16'($urandom);
        xs = xs ^ w[15:8] ^ w[7:0];
        exp_addr.push_back(i);
        exp_data.push_back(w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (ok) send_byte(bad_sum ? ~xs : xs);
    done_exp = ok && !bad_sum;
`else
    done_exp = ok;
`endif
    repeat (4) tick();
    check("sess_done", 32'(loadDone), 32'(done_exp));
    check("sess_error", 32'(loadError), 32'(!done_exp));
    check("sess_bip", 32'(bipReset), 32'(!done_exp));
    check("sess_count", 32'(wordCount), ok ? n : 0);
    check("sess_sb_empty", exp_addr.size(), 0);
  endtask

  initial begin
    logic [15:0] wq[$];
    logic [15:0] none[$];
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_bip", 32'(bipReset), 1);
    check("rst_wr", 32'(Wr), 0);
    check("rst_addr", 32'(addrToMemory), 0);
    check("rst_done", 32'(loadDone), 0);
    check("rst_error", 32'(loadError), 0);
    check("rst_count", 32'(wordCount), 0);

    wq = '{16'h1805, 16'h2002, 16'h0800};
    run_session(0, 3, wq, 1'b0);

    send_byte(8'h11);
    send_byte(8'h22);
    wq = '{16'h0000};
    run_session(0, 1, wq, 1'b0);

    run_session(0, 0, none, 1'b0);
    wq = '{16'hABCD};
    run_session(0, 1, wq, 1'b0);

    run_session(0, 2049, none, 1'b0);
    run_session(2, 1 << AL, none, 1'b0);

    // Abort after the first word of a two-word load.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    exp_addr.push_back(0);
    exp_data.push_back(16'h3C5A);
    send_byte(8'h3C);
    send_byte(8'h5A);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_wr", 32'(Wr), 0);
    check("abort_addr", 32'(addrToMemory), 0);
    check("abort_data", 32'(dataToMemory), 0);
    check("abort_count", 32'(wordCount), 0);
    check("abort_bip", 32'(bipReset), 1);
    check("abort_done_err", {30'd0, loadDone, loadError}, 0);
    check("abort_sb_empty", exp_addr.size(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_session(0, 2, none, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    run_session(1, 3, none, 1'b1);
`endif
    for (int s = 0; s < 12; s++) begin
      int n;
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
      run_session($urandom_range(0, 3), n, none, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
